postprocess_writeback: RTL

//  Sink end of the post-process output stream: takes each POX-lane beat from the

---
 rtl/acc_pkg.sv | 12 +
 rtl/pp_wb_fifo.sv | 54 +++++
 rtl/postprocess_writeback.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the post-process output path: writeback FSM states and lane width.
package acc_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/pp_wb_fifo.sv
// Synchronous beat FIFO, head visible combinationally; 1-cycle push-to-pop latency.
// Caller must not push when full unless it pops in the same cycle; clr empties it.
module pp_wb_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only slots behind a valid count are ever read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/postprocess_writeback.sv
// Writes post-process beats row-major into the output map; in_valid -> wr_en is 2 cycles when idle.
// No input backpressure: wr_ready stalls fill the FIFO, and a beat that cannot be stored sets sticky overflow.
module postprocess_writeback
  import acc_pkg::*;
#(
  parameter int POX        = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [ADDR_W-1:0]     cfg_row_stride,
  input  logic [CNT_W-1:0]      cfg_beats,
  input  logic [CNT_W-1:0]      cfg_rows,
  input  logic [POX*DATA_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [POX*DATA_W-1:0] wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BEAT_W = POX * DATA_W;
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] FIFO_CAP = FCW'(FIFO_DEPTH);

  wb_state_t state, state_nxt;

  logic [CNT_W-1:0]  beats_q, rows_q, col, row;
  logic [ADDR_W-1:0] stride_q, row_addr;
  logic              all_popped;

  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [BEAT_W-1:0] fifo_head;

  logic start_acc, is_run, accept, pop, push, drop;
  logic col_last, row_last, tile_end;

  assign start_acc = start && (state == ST_IDLE);
  assign is_run    = (state == ST_RUN);
  assign accept    = wr_en && wr_ready;
  assign col_last  = (col == beats_q - CNT_W'(1));
  assign row_last  = (row == rows_q - CNT_W'(1));

  // Pops stop once every beat of the tile has been handed to the write port.
  assign pop      = is_run && !fifo_empty && !all_popped && (!wr_en || wr_ready);
  assign push     = is_run && in_valid && ((fifo_count < FIFO_CAP) || (fifo_full && pop));
  assign drop     = in_valid && !push;
  assign tile_end = is_run && all_popped && accept;

  pp_wb_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .push    (push),
    .push_dat(in_data),
    .pop     (pop),
    .pop_dat (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ((cfg_beats == '0) || (cfg_rows == '0)) ? ST_DONE : ST_RUN;
      ST_RUN:  if (tile_end) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q    <= '0;
      rows_q     <= '0;
      stride_q   <= '0;
      col        <= '0;
      row        <= '0;
      row_addr   <= '0;
      all_popped <= 1'b0;
    end else if (start_acc) begin
      beats_q    <= cfg_beats;
      rows_q     <= cfg_rows;
      stride_q   <= cfg_row_stride;
      col        <= '0;
      row        <= '0;
      row_addr   <= cfg_base_addr;
      all_popped <= 1'b0;
    end else if (pop) begin
      if (col_last) begin
        col      <= '0;
        row      <= row + CNT_W'(1);
        row_addr <= row_addr + stride_q;
      end else begin
        col <= col + CNT_W'(1);
      end
      if (col_last && row_last) all_popped <= 1'b1;
    end
  end

  // Output register: address/data only change on a pop, so they hold through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (pop) begin
      wr_en   <= 1'b1;
      wr_addr <= row_addr + ADDR_W'(col);
      wr_data <= fifo_head;
    end else if (accept) begin
      wr_en <= 1'b0;
    end
  end

  // A beat dropped in the same cycle as start still counts against the new tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= (start_acc ? 1'b0 : overflow) | drop;
  end

endmodule
